// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix front-end and controller: mode codes,
// the key-gesture FSM state type and the mode decode helpers.
package led_pkg;

  typedef logic [2:0] mode_t;
  typedef logic [2:0] key_set_t;   // {key4, key3, key2}, 1 = pressed

  localparam mode_t MODE_OFF    = 3'd0;
  localparam mode_t MODE_SINGLE = 3'd1;
  localparam mode_t MODE_ROW    = 3'd2;
  localparam mode_t MODE_FLOW   = 3'd3;
  localparam mode_t MODE_BREATH = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_REL = 2'd2
  } key_state_t;

  // Chord decode; MODE_OFF marks an illegal key combination.
  function automatic mode_t chord_mode(input key_set_t set);
    mode_t m;
    case (set)
      3'b001:  m = MODE_SINGLE;
      3'b010:  m = MODE_ROW;
      3'b100:  m = MODE_FLOW;
      3'b011:  m = MODE_BREATH;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

  // Single-key decode with priority key2 > key3 > key4.
  function automatic mode_t priority_mode(input key_set_t set);
    mode_t m;
    if (set[0])      m = MODE_SINGLE;
    else if (set[1]) m = MODE_ROW;
    else if (set[2]) m = MODE_FLOW;
    else             m = MODE_OFF;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser plus debounce counter for one active-low push-button.
// Ports: clk, rst_n (async active-low), key_n (raw, low = pressed),
//        level (debounced, 1 = pressed).
module key_debounce
  import led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             pressed;

  assign pressed = ~sync[1];

  // Counter only runs while the synchronised level disagrees with the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      if (pressed == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_mode_decoder.sv
// Turns three raw push-buttons into registered display-mode commands with a
// one-cycle valid strobe per accepted gesture.
// Optional feature macro KEY_CHORD_EN: when defined, presses within a
// CHORD_CYCLES window are grouped into a chord (key2+key3 = breathing);
// when undefined, each press decodes immediately with priority key2>key3>key4.
// Ports: clk, rst_n (async active-low), key2/key3/key4 (raw, low = pressed),
//        keys_db {key4,key3,key2} debounced (1 = pressed),
//        mode (last accepted mode code), mode_valid (one-cycle strobe).
module key_mode_decoder
  import led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned CHORD_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key2,
  input  logic       key3,
  input  logic       key4,
  output logic [2:0] keys_db,
  output logic [2:0] mode,
  output logic       mode_valid
);

  if (DEB_CYCLES < 2 || CHORD_CYCLES < 1) begin : g_bad_params
    $error("key_mode_decoder: need DEB_CYCLES >= 2 and CHORD_CYCLES >= 1");
  end

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_key2 (
    .clk(clk), .rst_n(rst_n), .key_n(key2), .level(keys_db[0]));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_key3 (
    .clk(clk), .rst_n(rst_n), .key_n(key3), .level(keys_db[1]));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_key4 (
    .clk(clk), .rst_n(rst_n), .key_n(key4), .level(keys_db[2]));

  key_state_t state, state_d;
  key_set_t   keys_db_q, press, dec_set;
  mode_t      mode_d, dec_mode;
  logic       valid_d, dec_en;

`ifdef KEY_CHORD_EN
  // The press cycle itself is window cycle 0, so COLLECT covers the rest.
  localparam int unsigned WIN_LAST = (CHORD_CYCLES > 1) ? CHORD_CYCLES - 2 : 0;
  localparam int unsigned WIN_W    = (CHORD_CYCLES > 2) ? $clog2(CHORD_CYCLES - 1) : 1;

  key_set_t          chord, chord_d;
  logic [WIN_W-1:0]  win, win_d;
`endif

  assign press = keys_db & ~keys_db_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    mode_d  = mode;
    valid_d = 1'b0;
    dec_en  = 1'b0;
    dec_set = press;
`ifdef KEY_CHORD_EN
    chord_d = chord;
    win_d   = win;
`endif
    case (state)
      IDLE: begin
        if (|press) begin
`ifdef KEY_CHORD_EN
          if (CHORD_CYCLES == 1) begin
            dec_en = 1'b1;
          end else begin
            chord_d = press;
            win_d   = '0;
            state_d = COLLECT;
          end
`else
          dec_en = 1'b1;
`endif
        end
      end
`ifdef KEY_CHORD_EN
      COLLECT: begin
        chord_d = chord | press;
        win_d   = win + WIN_W'(1);
        dec_set = chord | press;
        if (win == WIN_W'(WIN_LAST)) dec_en = 1'b1;
      end
`endif
      WAIT_REL: begin
        if (keys_db == 3'b000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef KEY_CHORD_EN
    dec_mode = chord_mode(dec_set);
`else
    dec_mode = priority_mode(dec_set);
`endif
    // Illegal chords decode to MODE_OFF: mode is held and no strobe issued.
    if (dec_en) begin
      state_d = WAIT_REL;
      if (dec_mode != MODE_OFF) begin
        mode_d  = dec_mode;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode       <= MODE_OFF;
      mode_valid <= 1'b0;
      keys_db_q  <= '0;
`ifdef KEY_CHORD_EN
      chord      <= '0;
      win        <= '0;
`endif
    end else begin
      state      <= state_d;
      mode       <= mode_d;
      mode_valid <= valid_d;
      keys_db_q  <= keys_db;
`ifdef KEY_CHORD_EN
      chord      <= chord_d;
      win        <= win_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_mode_decoder.sv
// Directed bench for key_mode_decoder (DEB_CYCLES=4, CHORD_CYCLES=8).
module tb_key_mode_decoder;

  localparam int DEB   = 4;
  localparam int CHORD = 8;
`ifdef KEY_CHORD_EN
  localparam int LAT = CHORD;   // press event -> strobe
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key2, key3, key4;
  logic [2:0] keys_db;
  logic [2:0] mode;
  logic       mode_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_strobe = 0, n_double = 0;
  int strobe_cyc = 0, strobe_mode = 0, rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [2:0] prev_db = 3'b000;

  int base, n0;

  key_mode_decoder #(.DEB_CYCLES(DEB), .CHORD_CYCLES(CHORD)) dut (
    .clk(clk), .rst_n(rst_n), .key2(key2), .key3(key3), .key4(key4),
    .keys_db(keys_db), .mode(mode), .mode_valid(mode_valid));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and debounced-rise monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mode_valid) begin
      n_strobe++;
      strobe_cyc  = cyc;
      strobe_mode = int'(mode);
      if (prev_valid) n_double++;
    end
    prev_valid = mode_valid;
    if ((keys_db & ~prev_db) != 3'b000) rise_cyc = cyc;
    prev_db = keys_db;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    key2 = 1'b1; key3 = 1'b1; key4 = 1'b1;
    #100;
    check("rst_mode", int'(mode), 0);
    check("rst_valid", int'(mode_valid), 0);
    check("rst_keys_db", int'(keys_db), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(50);
    check("idle_no_strobe", n_strobe, 0);

    // Glitches shorter than the debounce time, then a clean key2 press.
    key2 = 1'b0; step(2); key2 = 1'b1; step(2);
    key2 = 1'b0; step(2); key2 = 1'b1; step(3);
    check("glitch_keys_db", int'(keys_db), 0);
    check("glitch_no_strobe", n_strobe, 0);
    key2 = 1'b0; base = cyc;
    step(10);
    key2 = 1'b1;
    step(14);
    check("key2_db_latency", rise_cyc - base, 2 + DEB);
    check("key2_strobe_cnt", n_strobe, 1);
    check("key2_strobe_mode", strobe_mode, 1);
    check("key2_strobe_lat", strobe_cyc - rise_cyc, LAT);
    check("key2_mode_held", int'(mode), 1);
    check("key2_released", int'(keys_db), 0);

`ifdef KEY_CHORD_EN
    // key3 three cycles after key2: inside the window -> breathing.
    n0 = n_strobe;
    key2 = 1'b0; step(3); key3 = 1'b0; step(20);
    check("chord_strobe_cnt", n_strobe, n0 + 1);
    check("chord_mode", int'(mode), 4);
    key2 = 1'b1; key3 = 1'b1; step(10);
    // key3 eight cycles later: outside the window, ignored until release.
    n0 = n_strobe;
    key2 = 1'b0; step(8); key3 = 1'b0; step(20);
    check("gap_strobe_cnt", n_strobe, n0 + 1);
    check("gap_mode", int'(mode), 1);
    key2 = 1'b1; key3 = 1'b1; step(10);
    check("gap_no_late", n_strobe, n0 + 1);
`else
    // key2+key3 together: priority gives key2, one cycle after the press.
    n0 = n_strobe;
    key2 = 1'b0; key3 = 1'b0; base = cyc;
    step(15);
    check("simul_strobe_cnt", n_strobe, n0 + 1);
    check("simul_mode", strobe_mode, 1);
    check("simul_lat", strobe_cyc - base, 2 + DEB + LAT);
    // Re-press key2 while key3 is still held: no new gesture.
    key2 = 1'b1; step(10);
    key2 = 1'b0; step(15);
    check("no_rearm", n_strobe, n0 + 1);
    key2 = 1'b1; key3 = 1'b1; step(10);
    check("simul_released", int'(keys_db), 0);
`endif

    // key4 alone -> flow.
    n0 = n_strobe;
    key4 = 1'b0; step(20);
    check("key4_strobe_cnt", n_strobe, n0 + 1);
    check("key4_mode", int'(mode), 3);
    key4 = 1'b1; step(10);

    // key2+key4 together.
    n0 = n_strobe;
    key2 = 1'b0; key4 = 1'b0; step(20);
`ifdef KEY_CHORD_EN
    check("illegal_no_strobe", n_strobe, n0);
    check("illegal_mode_kept", int'(mode), 3);
`else
    check("k2k4_strobe_cnt", n_strobe, n0 + 1);
    check("k2k4_priority", int'(mode), 1);
`endif
    key2 = 1'b1; key4 = 1'b1; step(10);

    // Reset three cycles after the press event, key kept held.
    key2 = 1'b0; step(2 + DEB + 3);
    n0 = n_strobe;
    rst_n = 1'b0; #1;
    check("midrst_mode", int'(mode), 0);
    check("midrst_valid", int'(mode_valid), 0);
    check("midrst_keys_db", int'(keys_db), 0);
    step(2);
    rst_n = 1'b1; base = cyc;
    step(20);
    check("postrst_strobe_cnt", n_strobe, n0 + 1);
    check("postrst_lat", strobe_cyc - base, 2 + DEB + LAT);
    check("postrst_mode", int'(mode), 1);
    key2 = 1'b1; step(10);

    check("no_double_strobe", n_double, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
